// File: rtl/eeprom_bram_arbiter.sv
// Arbitrates the shared save BRAM between the EEPROM core (fixed priority) and the HPS port.
// Optional macro EEPROM_ARB_LOCK_EN adds hps_lock_i, which discards EEPROM writes during a load.
module eeprom_bram_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [AW-1:0] mask_i,
  input  logic [AW-1:0] eep_addr_i,
  input  logic [DW-1:0] eep_d_i,
  input  logic          eep_wr_i,
  input  logic          eep_rd_i,
  output logic [DW-1:0] eep_q_o,
  input  logic          hps_req_i,
  input  logic          hps_we_i,
  input  logic [AW-1:0] hps_addr_i,
  input  logic [DW-1:0] hps_d_i,
  output logic          hps_ack_o,
  output logic [DW-1:0] hps_q_o,
`ifdef EEPROM_ARB_LOCK_EN
  input  logic          hps_lock_i,
`endif
  output logic [AW-1:0] bram_addr_o,
  output logic [DW-1:0] bram_d_o,
  output logic          bram_we_o,
  input  logic [DW-1:0] bram_q_i,
  input  logic          clr_dirty_i,
  output logic          dirty_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    HPS_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] eep_q_q;
  logic [DW-1:0] hps_q_q;
  logic          eep_pend_q;
  logic          hps_we_q;
  logic          dirty_q;
  logic          eep_g;
  logic          hps_g;
  logic          eep_we_ok;
  logic          wr_lock;

`ifdef EEPROM_ARB_LOCK_EN
  assign wr_lock = hps_lock_i;
`else
  assign wr_lock = 1'b0;
`endif

  always_comb begin
    eep_g       = ~rst_i & en_i & (eep_wr_i | eep_rd_i);
    hps_g       = ~rst_i & hps_req_i & ~eep_g & (state_q == IDLE);
    eep_we_ok   = eep_wr_i & ~wr_lock;
    bram_addr_o = addr_q;
    bram_d_o    = {DW{1'b0}};
    bram_we_o   = 1'b0;
    if (rst_i) begin
      bram_addr_o = {AW{1'b0}};
    end else if (eep_g) begin
      bram_addr_o = eep_addr_i & mask_i;
      bram_d_o    = eep_d_i;
      bram_we_o   = eep_we_ok;
    end else if (hps_g) begin
      bram_addr_o = hps_addr_i;
      bram_d_o    = hps_d_i;
      bram_we_o   = hps_we_i;
    end else begin
      bram_we_o   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hps_g) state_d = HPS_WAIT;
        else       state_d = IDLE;
      end
      HPS_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= {AW{1'b0}};
      eep_q_q    <= {DW{1'b0}};
      hps_q_q    <= {DW{1'b0}};
      eep_pend_q <= 1'b0;
      hps_we_q   <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= bram_addr_o;
      // A simultaneous write+read strobe drops the read, so no capture is scheduled.
      eep_pend_q <= eep_g & eep_rd_i & ~eep_wr_i;
      if (eep_pend_q) eep_q_q <= bram_q_i;
      if (hps_g) hps_we_q <= hps_we_i;
      if ((state_q == HPS_WAIT) && !hps_we_q) hps_q_q <= bram_q_i;
      if (eep_g & eep_we_ok) dirty_q <= 1'b1;
      else if (clr_dirty_i)  dirty_q <= 1'b0;
    end
  end

  // Read data is forwarded straight from the BRAM in the ack cycle so it is valid with ack.
  assign hps_ack_o = (state_q == HPS_WAIT) & ~rst_i;
  assign hps_q_o   = (hps_ack_o & ~hps_we_q) ? bram_q_i : hps_q_q;
  assign eep_q_o   = eep_q_q;
  assign dirty_o   = dirty_q;

endmodule

// File: tb/tb_eeprom_bram_arbiter.sv
// Randomised + directed bench for eeprom_bram_arbiter with an in-bench reference model.
module tb_eeprom_bram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [AW-1:0] mask = 13'h1FFF;
  logic [AW-1:0] eep_addr = 13'h0000;
  logic [DW-1:0] eep_d = 8'h00;
  logic eep_wr = 1'b0, eep_rd = 1'b0;
  logic [DW-1:0] eep_q;
  logic hps_req = 1'b0, hps_we = 1'b0;
  logic [AW-1:0] hps_addr = 13'h0000;
  logic [DW-1:0] hps_d = 8'h00;
  logic hps_ack;
  logic [DW-1:0] hps_q;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_d;
  logic bram_we;
  logic [DW-1:0] bram_q;
  logic clr_dirty = 1'b0;
  logic dirty;
`ifdef EEPROM_ARB_LOCK_EN
  logic hps_lock = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  logic [DW-1:0] env_mem [0:8191];
  logic [DW-1:0] ref_mem [0:8191];

  logic m_busy = 1'b0, m_busy_we = 1'b0, m_eep_pend = 1'b0, m_dirty = 1'b0;
  logic [DW-1:0] m_eep_q = 8'h00, m_hps_q = 8'h00, m_rd = 8'h00;
  logic [AW-1:0] m_last_addr = 13'h0000;

  eeprom_bram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mask_i(mask),
    .eep_addr_i(eep_addr), .eep_d_i(eep_d), .eep_wr_i(eep_wr), .eep_rd_i(eep_rd),
    .eep_q_o(eep_q),
    .hps_req_i(hps_req), .hps_we_i(hps_we), .hps_addr_i(hps_addr), .hps_d_i(hps_d),
    .hps_ack_o(hps_ack), .hps_q_o(hps_q),
`ifdef EEPROM_ARB_LOCK_EN
    .hps_lock_i(hps_lock),
`endif
    .bram_addr_o(bram_addr), .bram_d_o(bram_d), .bram_we_o(bram_we), .bram_q_i(bram_q),
    .clr_dirty_i(clr_dirty), .dirty_o(dirty)
  );

  always #5 clk = ~clk;

  // Single-port BRAM stand-in, read-before-write, one cycle latency.
  always @(posedge clk) begin
    if (bram_we) env_mem[bram_addr] <= bram_d;
    bram_q <= env_mem[bram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: derive this cycle's outputs from the arbitration rules, then advance.
  always @(negedge clk) begin
    logic eg, hg, wr_ok, lock_eff, e_we, e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d, e_hps_q;
    if (chk_en) begin
`ifdef EEPROM_ARB_LOCK_EN
      lock_eff = hps_lock;
`else
      lock_eff = 1'b0;
`endif
      eg     = !rst && en && (eep_wr || eep_rd);
      hg     = !rst && hps_req && !eg && !m_busy;
      wr_ok  = eep_wr && !lock_eff;
      e_addr = rst ? 13'h0000 : eg ? (eep_addr & mask) : hg ? hps_addr : m_last_addr;
      e_we   = eg ? wr_ok : (hg ? hps_we : 1'b0);
      e_d    = eg ? eep_d : hps_d;
      e_ack  = m_busy && !rst;
      e_hps_q = (e_ack && !m_busy_we) ? m_rd : m_hps_q;
      chk("bram_addr", 32'(bram_addr), 32'(e_addr));
      chk("bram_we", 32'(bram_we), 32'(e_we));
      if (e_we) chk("bram_d", 32'(bram_d), 32'(e_d));
      chk("hps_ack", 32'(hps_ack), 32'(e_ack));
      chk("hps_q", 32'(hps_q), 32'(e_hps_q));
      chk("eep_q", 32'(eep_q), 32'(m_eep_q));
      chk("dirty", 32'(dirty), 32'(m_dirty));
      if (rst) begin
        m_busy = 1'b0; m_busy_we = 1'b0; m_eep_pend = 1'b0; m_dirty = 1'b0;
        m_eep_q = 8'h00; m_hps_q = 8'h00; m_last_addr = 13'h0000;
      end else begin
        if (m_eep_pend) m_eep_q = m_rd;
        if (m_busy && !m_busy_we) m_hps_q = m_rd;
        if (eg && wr_ok) m_dirty = 1'b1;
        else if (clr_dirty) m_dirty = 1'b0;
        m_eep_pend = eg && eep_rd && !eep_wr;
        if (hg) m_busy_we = hps_we;
        m_busy = hg;
        m_last_addr = e_addr;
      end
      m_rd = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_d;
    end
  end

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 8192; i++) begin
      v = 8'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[13'h005] = 8'hA5; ref_mem[13'h005] = 8'hA5;
    env_mem[13'h030] = 8'h11; ref_mem[13'h030] = 8'h11;

    @(posedge clk);
    chk_en = 1'b1;
    #1;
    step();
    chk("rst_eep_q", 32'(eep_q), 32'h0);
    chk("rst_hps_q", 32'(hps_q), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    chk("rst_ack", 32'(hps_ack), 32'h0);
    chk("rst_we", 32'(bram_we), 32'h0);
    chk("rst_addr", 32'(bram_addr), 32'h0);

    // Masked EEPROM read
    rst = 1'b0; en = 1'b1; mask = 13'h07FF; eep_addr = 13'h1005; eep_rd = 1'b1;
    #1 chk("rd_addr", 32'(bram_addr), 32'h005);
    step(); eep_rd = 1'b0;
    chk("rd_lat1", 32'(eep_q), 32'h00);
    step(); chk("rd_q", 32'(eep_q), 32'hA5);
    step(); chk("rd_hold", 32'(eep_q), 32'hA5);

    // EEPROM write with simultaneous clear: set wins
    eep_addr = 13'h0010; eep_d = 8'h3C; eep_wr = 1'b1; clr_dirty = 1'b1;
    #1 chk("wr_we", 32'(bram_we), 32'h1);
    step(); eep_wr = 1'b0; clr_dirty = 1'b0;
    chk("dirty_set_wins", 32'(dirty), 32'h1);
    clr_dirty = 1'b1;
    step(); clr_dirty = 1'b0;
    chk("dirty_clr", 32'(dirty), 32'h0);
    chk("mem_010", 32'(env_mem[13'h010]), 32'h3C);

    // HPS read, req held through the ack cycle
    hps_req = 1'b1; hps_we = 1'b0; hps_addr = 13'h0010;
    #1 chk("hrd_addr", 32'(bram_addr), 32'h010);
    step();
    chk("hrd_ack", 32'(hps_ack), 32'h1);
    chk("hrd_q", 32'(hps_q), 32'h3C);
    chk("hrd_no_regrant", 32'(bram_we), 32'h0);
    step(); hps_req = 1'b0;
    chk("hrd_ack_pulse", 32'(hps_ack), 32'h0);
    chk("hrd_q_hold", 32'(hps_q), 32'h3C);

    // HPS write colliding with an EEPROM read
    hps_req = 1'b1; hps_we = 1'b1; hps_addr = 13'h0020; hps_d = 8'h77;
    eep_addr = 13'h0000; eep_rd = 1'b1;
    #1 chk("col_eep_first", 32'(bram_addr), 32'h000);
    step(); eep_rd = 1'b0;
    #1 chk("col_hps_addr", 32'(bram_addr), 32'h020);
    chk("col_hps_we", 32'(bram_we), 32'h1);
    step();
    chk("col_ack", 32'(hps_ack), 32'h1);
    step(); hps_req = 1'b0;
    chk("col_dirty", 32'(dirty), 32'h0);
    chk("mem_020", 32'(env_mem[13'h020]), 32'h77);

    // HPS read, EEPROM write in the ack cycle, then reset
    hps_req = 1'b1; hps_we = 1'b0; hps_addr = 13'h0020;
    step(); eep_addr = 13'h0040; eep_d = 8'h55; eep_wr = 1'b1;
    #1 chk("w_ack", 32'(hps_ack), 32'h1);
    chk("w_hps_q", 32'(hps_q), 32'h77);
    step(); eep_wr = 1'b0; hps_req = 1'b0; rst = 1'b1;
    #1 chk("w_rst_ack", 32'(hps_ack), 32'h0);
    step(); rst = 1'b0;
    chk("post_rst_hps_q", 32'(hps_q), 32'h0);
    chk("post_rst_eep_q", 32'(eep_q), 32'h0);
    chk("post_rst_dirty", 32'(dirty), 32'h0);

    // Reset cancels a pending EEPROM capture and a pending HPS ack
    eep_addr = 13'h0005; eep_rd = 1'b1;
    step(); eep_rd = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    chk("cancel_eep_q", 32'(eep_q), 32'h0);
    hps_req = 1'b1; hps_we = 1'b0; hps_addr = 13'h0010;
    step(); hps_req = 1'b0; rst = 1'b1;
    #1 chk("cancel_ack", 32'(hps_ack), 32'h0);
    step(); rst = 1'b0;
    chk("cancel_ack_after", 32'(hps_ack), 32'h0);
    chk("cancel_hps_q", 32'(hps_q), 32'h0);

`ifdef EEPROM_ARB_LOCK_EN
    hps_lock = 1'b1; eep_addr = 13'h0030; eep_d = 8'h99; eep_wr = 1'b1;
    #1 chk("lock_we", 32'(bram_we), 32'h0);
    step(); eep_wr = 1'b0; eep_rd = 1'b1;
    chk("lock_dirty", 32'(dirty), 32'h0);
    step(); eep_rd = 1'b0;
    step(); chk("lock_rd", 32'(eep_q), 32'h11);
    hps_lock = 1'b0;
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int s;
      step();
      rst = ($urandom_range(299) == 0);
      en = ($urandom_range(7) != 0);
      mask = ($urandom_range(1) == 1) ? 13'h1FFF : 13'h00FF;
      eep_addr = 13'($urandom_range(511));
      eep_d = 8'($urandom);
      s = $urandom_range(9);
      eep_wr = (s < 2) || (s == 4);
      eep_rd = (s >= 2) && (s <= 4);
      clr_dirty = ($urandom_range(15) == 0);
`ifdef EEPROM_ARB_LOCK_EN
      hps_lock = ($urandom_range(3) == 0);
`endif
      if (!hps_req) begin
        if ($urandom_range(2) == 0) begin
          hps_req = 1'b1;
          hps_we = 1'($urandom_range(1));
          hps_addr = 13'($urandom_range(511));
          hps_d = 8'($urandom);
        end
      end else if ($urandom_range(3) == 0) begin
        hps_req = 1'b0;
      end
    end
    step();
    rst = 1'b0; eep_wr = 1'b0; eep_rd = 1'b0; hps_req = 1'b0; clr_dirty = 1'b0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
